copro_result_buffer: RTL and testbench
======================================

Name: copro_result_buffer

Overview:
- Result stage directly downstream of the coprocessor ALU. The ALU produces one registered result per cycle and has no backpressure.
- This block captures every ALU result (result, hartid, id, rd, we) into a small in-order FIFO.
- It presents the FIFO head to the CV-X-IF result interface with a valid/ready handshake.
- It raises full_o so the issue logic stops accepting new offloaded instructions before entries are lost.

Parameters:
- XLEN, 32, width of result data.
- DEPTH, 4, number of FIFO entries; power of two, at least 2.
- hartid_t, logic, hart identifier type.
- id_t, logic, instruction identifier type.

Ports:
- clk_i  input  1  clock.
- rst_i  input  1  asynchronous active-high reset.
- flush_i  input  1  synchronous drop of all buffered entries.
- alu_valid_i  input  1  ALU result valid this cycle.
- alu_result_i  input  XLEN  ALU result.
- alu_hartid_i  input  hartid_t  hart of result.
- alu_id_i  input  id_t  instruction id.
- alu_rd_i  input  5  destination register.
- alu_we_i  input  1  register write enable.
- full_o  output  1  issue stall; high when fewer than 2 free entries.
- count_o  output  $clog2(DEPTH+1)  current occupancy.
- overflow_o  output  1  sticky error, push attempted with no free slot.
- result_valid_o  output  1  head entry valid.
- result_ready_i  input  1  consumer accepts head.
- result_data_o  output  XLEN  head result.
- result_hartid_o  output  hartid_t  head hartid.
- result_id_o  output  id_t  head id.
- result_rd_o  output  5  head rd.
- result_we_o  output  1  head we.

Behaviour:
- Reset (rst_i high, asynchronous, active-high): pointers and count go to 0, overflow_o goes to 0. All result_* outputs are 0, and result_valid_o is 0.
- Push: alu_valid_i=1 writes one entry at the tail on the clock edge. Entries with we=0 (NOP) are queued too; every id must be reported.
- Pop: result_valid_o & result_ready_i retires the head on the clock edge.
- Ordering: strictly in order; no reordering, no merging.
- Latency: an entry pushed in cycle N is visible on result_* in cycle N+1 at the earliest (registered storage, head read out of the array).
- result_valid_o = (count != 0).
- result_* are held stable while result_valid_o & !result_ready_i.
- When result_valid_o=0, result_* are driven to 0.
- Simultaneous push and pop:
  - count is unchanged.
  - This is legal even when count==DEPTH: the pop frees the slot written in the same cycle.
- Full with no pop: a push while count==DEPTH & !(result_valid_o & result_ready_i) drops the entry. overflow_o is set and stays set until reset. Existing entries are untouched.
- full_o = (count >= DEPTH-1). The one-entry margin covers the ALU's registered output stage, so an instruction issued while full_o was low can always land.
- Pointers are $clog2(DEPTH) bits and wrap naturally modulo DEPTH. count saturates by construction (never exceeds DEPTH).
- flush_i = 1:
  - Next cycle count=0, pointers equal, result_valid_o=0.
  - A push and/or pop in the same cycle is discarded.
  - overflow_o is unaffected.
- Reset mid-handshake: an entry being offered is lost. Nothing is retained across reset.

Optional Feature:
- Macro: COPRO_RESULT_BUFFER_BYPASS_EN.
- With the macro:
  - When count==0 & alu_valid_i & !flush_i, the ALU fields drive result_* combinationally and result_valid_o=1 in the same cycle.
  - If result_ready_i=1 in that cycle, the entry is not written (count stays 0).
  - If result_ready_i=0, the entry is written as a normal push.
  - Zero-latency path.
- Without the macro: no combinational path from alu_* to result_*; minimum latency is 1 cycle as above.

Decomposition:
- Shared package cvxif_instr_pkg gets:
  - COPRO_RESULT_DEPTH default constant.
  - A rd width constant (5).
- The entry struct {result, hartid, id, rd, we} is a module-local typedef, since hartid_t and id_t are parameters.
- Sub-module copro_result_fifo: generic DEPTH x entry_t storage with push/pop/flush, pointers and count. The top level adds full_o thresholding, overflow tracking, the output zeroing and the optional bypass.

Test Plan:
- Single push (result=0x0000_00AA, id=3, rd=5, we=1) with result_ready_i=1: in cycle N+1, result_valid_o=1 with those fields; next cycle count_o=0 and result_valid_o=0.
- Four pushes (id 0..3) with result_ready_i=0:
  - count_o=4; full_o rises when count_o=3.
  - Release ready: ids appear 0,1,2,3 in order with fields held stable while stalled.
- With count=4, push id=7 and pop in the same cycle: head id 0 retires, count_o stays 4, overflow_o=0, id 7 emerges last.
- With count=4 and ready=0, push id=9: overflow_o=1 (sticky), count_o=4, id 9 never appears.
- With count=3, assert flush_i together with a push: the next cycle count_o=0 and result_valid_o=0. Then a new push (id=2) is the next output.
- Bypass build, empty buffer:
  - Push id=1 with ready=1: result_valid_o=1 and id=1 in the same cycle, count_o remains 0.
  - Non-bypass build: the same stimulus gives the output one cycle later.

Source files
------------

// File: rtl/cvxif_instr_pkg.sv
// cvxif_instr_pkg: shared constants for the CV-X-IF coprocessor result path
package cvxif_instr_pkg;
  localparam int COPRO_RESULT_DEPTH = 4;
  localparam int RD_W = 5;
endpackage

// File: rtl/copro_result_fifo.sv
// copro_result_fifo: in-order DEPTH x entry_t storage with push/pop/flush, pointers and occupancy count
module copro_result_fifo #(
  parameter int DEPTH = 4,
  parameter type entry_t = logic
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         flush_i,
  input  logic                         push_i,
  input  logic                         pop_i,
  input  entry_t                       wdata_i,
  output entry_t                       rdata_o,
  output logic [$clog2(DEPTH+1)-1:0]   count_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  entry_t mem [DEPTH];
  logic [AW-1:0] wptr, rptr;
  assign rdata_o = mem[rptr];
  // pointers and count; flush discards any same-cycle push/pop
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wptr    <= '0;
      rptr    <= '0;
      count_o <= '0;
    end else if (flush_i) begin
      wptr    <= '0;
      rptr    <= '0;
      count_o <= '0;
    end else begin
      if (push_i) wptr <= wptr + AW'(1);
      if (pop_i) rptr <= rptr + AW'(1);
      count_o <= count_o + CW'(push_i) - CW'(pop_i);
    end
  end
  // entry storage; contents need no reset because empty slots are never presented
  always_ff @(posedge clk_i) begin
    if (push_i && !flush_i) mem[wptr] <= wdata_i;
  end
endmodule

// File: rtl/copro_result_buffer.sv
// copro_result_buffer: buffers ALU results in order for the CV-X-IF result interface.
// Optional zero-latency bypass when empty: define COPRO_RESULT_BUFFER_BYPASS_EN.
module copro_result_buffer
  import cvxif_instr_pkg::*;
#(
  parameter int  XLEN     = 32,
  parameter int  DEPTH    = COPRO_RESULT_DEPTH,
  parameter type hartid_t = logic,
  parameter type id_t     = logic
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       flush_i,
  input  logic                       alu_valid_i,
  input  logic [XLEN-1:0]            alu_result_i,
  input  hartid_t                    alu_hartid_i,
  input  id_t                        alu_id_i,
  input  logic [RD_W-1:0]            alu_rd_i,
  input  logic                       alu_we_i,
  output logic                       full_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o,
  output logic                       overflow_o,
  output logic                       result_valid_o,
  input  logic                       result_ready_i,
  output logic [XLEN-1:0]            result_data_o,
  output hartid_t                    result_hartid_o,
  output id_t                        result_id_o,
  output logic [RD_W-1:0]            result_rd_o,
  output logic                       result_we_o
);
  localparam int CW = $clog2(DEPTH+1);
  typedef struct packed {
    logic [XLEN-1:0] result;
    hartid_t         hartid;
    id_t             id;
    logic [RD_W-1:0] rd;
    logic            we;
  } entry_t;
  entry_t alu_e, head, out_e;
  logic has, byp, pop, push, at_cap;
  assign alu_e  = '{alu_result_i, alu_hartid_i, alu_id_i, alu_rd_i, alu_we_i};
  assign has    = count_o != '0;
  assign at_cap = count_o == CW'(DEPTH);
`ifdef COPRO_RESULT_BUFFER_BYPASS_EN
  assign byp = !has && alu_valid_i && !flush_i;
`else
  assign byp = 1'b0;
`endif
  assign pop            = has && result_ready_i;
  assign push           = alu_valid_i && !(byp && result_ready_i) && (!at_cap || pop);
  assign result_valid_o = has || byp;
  assign full_o         = count_o >= CW'(DEPTH-1);
  assign out_e          = has ? head : byp ? alu_e : '0;
  assign result_data_o   = out_e.result;
  assign result_hartid_o = out_e.hartid;
  assign result_id_o     = out_e.id;
  assign result_rd_o     = out_e.rd;
  assign result_we_o     = out_e.we;
  copro_result_fifo #(.DEPTH(DEPTH), .entry_t(entry_t)) fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .flush_i (flush_i),
    .push_i  (push),
    .pop_i   (pop),
    .wdata_i (alu_e),
    .rdata_o (head),
    .count_o (count_o)
  );
  // sticky overflow: a push was dropped because every slot was occupied and none retired
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) overflow_o <= 1'b0;
    else if (alu_valid_i && !flush_i && at_cap && !pop) overflow_o <= 1'b1;
  end
endmodule

// File: tb/tb_copro_result_buffer.sv
// tb_copro_result_buffer: directed self-checking bench for copro_result_buffer
module tb_copro_result_buffer;
  logic clk = 1'b0, rst = 1'b1, flush = 1'b0, alu_valid = 1'b0, alu_we = 1'b0, ready = 1'b0;
  logic [31:0] alu_result = '0;
  logic [1:0]  alu_hartid = '0;
  logic [3:0]  alu_id = '0;
  logic [4:0]  alu_rd = '0;
  logic        full, overflow, rvalid, rwe;
  logic [2:0]  count;
  logic [31:0] rdata;
  logic [1:0]  rhartid;
  logic [3:0]  rid;
  logic [4:0]  rrd;
  int checks = 0, errors = 0;
  logic [3:0] exp_ids [4] = '{4'd1, 4'd2, 4'd3, 4'd7};

  copro_result_buffer #(.XLEN(32), .DEPTH(4), .hartid_t(logic [1:0]), .id_t(logic [3:0])) dut (
    .clk_i(clk), .rst_i(rst), .flush_i(flush), .alu_valid_i(alu_valid), .alu_result_i(alu_result),
    .alu_hartid_i(alu_hartid), .alu_id_i(alu_id), .alu_rd_i(alu_rd), .alu_we_i(alu_we),
    .full_o(full), .count_o(count), .overflow_o(overflow), .result_valid_o(rvalid),
    .result_ready_i(ready), .result_data_o(rdata), .result_hartid_o(rhartid), .result_id_o(rid),
    .result_rd_o(rrd), .result_we_o(rwe)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [3:0] id, input logic [31:0] res, input logic [4:0] rd, input logic we, input logic [1:0] hart);
    alu_valid = 1'b1; alu_id = id; alu_result = res; alu_rd = rd; alu_we = we; alu_hartid = hart;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    alu_valid = 1'b0;
    flush = 1'b0;
    #1;
  endtask

  initial begin
    #12 rst = 1'b0;
    #1;
    chk("rst_count", count, 0);
    chk("rst_valid", rvalid, 0);
    chk("rst_data", rdata, 0);
    chk("rst_id", rid, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_full", full, 0);
    // single push with ready high
    ready = 1'b1;
    drive(4'd3, 32'h0000_00AA, 5'd5, 1'b1, 2'd1);
    #1;
`ifdef COPRO_RESULT_BUFFER_BYPASS_EN
    chk("byp_valid", rvalid, 1);
    chk("byp_id", rid, 3);
    chk("byp_data", rdata, 32'hAA);
    tick();
    chk("byp_count", count, 0);
    chk("byp_valid_after", rvalid, 0);
`else
    chk("nobyp_same_cycle_valid", rvalid, 0);
    tick();
    chk("s1_valid", rvalid, 1);
    chk("s1_data", rdata, 32'hAA);
    chk("s1_id", rid, 3);
    chk("s1_rd", rrd, 5);
    chk("s1_we", rwe, 1);
    chk("s1_hart", rhartid, 1);
    chk("s1_count", count, 1);
    tick();
    chk("s1_count_after", count, 0);
    chk("s1_valid_after", rvalid, 0);
    chk("s1_data_zero", rdata, 0);
`endif
    // four pushes with ready low
    ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive(4'(i), 32'h100 + 32'(i), 5'(i + 1), 1'(i), 2'(i));
      tick();
      chk("fill_count", count, 64'(i + 1));
      chk("fill_full", full, (i >= 2) ? 1 : 0);
    end
    chk("fill_head_id", rid, 0);
    tick();
    chk("stall_id", rid, 0);
    chk("stall_data", rdata, 32'h100);
    chk("stall_valid", rvalid, 1);
    // push and pop while full
    ready = 1'b1;
    drive(4'd7, 32'h777, 5'd7, 1'b1, 2'd3);
    tick();
    ready = 1'b0;
    #1;
    chk("pp_count", count, 4);
    chk("pp_overflow", overflow, 0);
    chk("pp_head", rid, 1);
    chk("pp_data", rdata, 32'h101);
    // push while full without pop
    drive(4'd9, 32'h999, 5'd9, 1'b1, 2'd0);
    tick();
    chk("ov_flag", overflow, 1);
    chk("ov_count", count, 4);
    chk("ov_head", rid, 1);
    // drain in order
    ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk("drain_valid", rvalid, 1);
      chk("drain_id", rid, exp_ids[k]);
      tick();
    end
    chk("drain_count", count, 0);
    chk("drain_valid_end", rvalid, 0);
    chk("ov_sticky", overflow, 1);
    // flush with a simultaneous push
    ready = 1'b0;
    for (int i = 4; i < 7; i++) begin
      drive(4'(i), 32'h200 + 32'(i), 5'd1, 1'b1, 2'd0);
      tick();
    end
    chk("pre_flush_count", count, 3);
    chk("pre_flush_full", full, 1);
    drive(4'd8, 32'h888, 5'd8, 1'b1, 2'd0);
    flush = 1'b1;
    tick();
    chk("flush_count", count, 0);
    chk("flush_valid", rvalid, 0);
    chk("flush_overflow", overflow, 1);
    drive(4'd2, 32'h222, 5'd2, 1'b0, 2'd2);
    tick();
    chk("post_flush_valid", rvalid, 1);
    chk("post_flush_id", rid, 2);
    chk("post_flush_count", count, 1);
    chk("post_flush_we", rwe, 0);
    // reset while an entry is offered
    ready = 1'b0;
    rst = 1'b1;
    #1;
    chk("mid_rst_count", count, 0);
    chk("mid_rst_valid", rvalid, 0);
    chk("mid_rst_id", rid, 0);
    chk("mid_rst_overflow", overflow, 0);
    #3 rst = 1'b0;
    tick();
    chk("after_rst_valid", rvalid, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
